// File: rtl/sad_controller.sv
// Sum-of-absolute-differences controller: one shared adder is sequenced
// through SUB, ABS and ACC steps for each accepted a/b operand pair.
module sad_controller #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned ACC_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   sad,
    output logic               overflow
);

    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned SW = ACC_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SUB  = 3'd2,
        ABS  = 3'd3,
        ACC  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [DW-1:0]      diff;
    logic [SW-1:0]      add_x;
    logic [SW-1:0]      add_y;
    logic               add_cin;
    logic [SW-1:0]      sum;
    logic               in_ready_nx;
    logic               busy_nx;
    logic               done_nx;

    // State register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= in_ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (len != '0) ? LOAD : DONE;
            LOAD: if (in_valid) state_nx = SUB;
            SUB:  state_nx = ABS;
            ABS:  state_nx = ACC;
            ACC:  state_nx = (count == COUNT_W'(1)) ? DONE : LOAD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they align with it
    always_comb begin
        in_ready_nx = (state_nx == LOAD);
        busy_nx     = (state_nx != IDLE);
        done_nx     = (state_nx == DONE);
    end

    // Shared adder operand steering: a-b, then negate, then accumulate
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        unique case (state)
            SUB: begin
                add_x   = SW'($signed(a_r));
                add_y   = ~SW'($signed(b_r));
                add_cin = 1'b1;
            end
            ABS: begin
                add_x   = SW'(~diff);
                add_cin = 1'b1;
            end
            ACC: begin
                add_x = SW'(sad);
                add_y = SW'(diff);
            end
            default: ;
        endcase
    end

    assign sum = add_x + add_y + SW'(add_cin);

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            diff     <= '0;
            sad      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    count    <= len;
                    sad      <= '0;
                    overflow <= 1'b0;
                end
                LOAD: if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                end
                SUB: diff <= sum[DW-1:0];
                ABS: if (diff[WIDTH]) diff <= sum[DW-1:0];
                ACC: begin
                    if (sum[ACC_W]) begin
                        sad      <= '1;
                        overflow <= 1'b1;
                    end else begin
                        sad <= sum[ACC_W-1:0];
                    end
                    count <= count - COUNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_controller.sv
// Directed bench for sad_controller: a 24-bit and a 17-bit accumulator
// instance share the same stimulus and are checked against hand-computed values.
module tb_sad_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;

    logic        in_ready1, busy1, done1, ovf1;
    logic [23:0] sad1;
    logic        in_ready2, busy2, done2, ovf2;
    logic [16:0] sad2;

    int errors = 0;
    int checks = 0;

    sad_controller #(.WIDTH(16), .COUNT_W(8), .ACC_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .busy(busy1), .done(done1), .sad(sad1), .overflow(ovf1)
    );

    sad_controller #(.WIDTH(16), .COUNT_W(8), .ACC_W(17)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .busy(busy2), .done(done2), .sad(sad2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for in_ready, presents one pair for the accept cycle, then drops valid
    task automatic send_pair(input logic [15:0] pa, input logic [15:0] pb);
        int n = 0;
        while (!in_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready1) check("in_ready_timeout", 32'(in_ready1), 32'd1);
        in_valid = 1'b1;
        a        = pa;
        b        = pb;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done1) check("done_timeout", 32'(done1), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_sad", 32'(sad1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy1), 32'd0);

        // len=1, 5-3: done exactly four cycles after the accept cycle
        pulse_start(8'd1);
        check("load_in_ready", 32'(in_ready1), 32'd1);
        check("load_busy", 32'(busy1), 32'd1);
        send_pair(16'd5, 16'd3);
        check("lat_sub_done", 32'(done1), 32'd0);
        check("lat_sub_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        check("lat_abs_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("lat_acc_done", 32'(done1), 32'd0);
        @(negedge clk);
        check("lat_done", 32'(done1), 32'd1);
        check("lat_done_busy", 32'(busy1), 32'd1);
        check("p1_sad", 32'(sad1), 32'd2);
        check("p1_ovf", 32'(ovf1), 32'd0);
        @(negedge clk);
        check("p1_done_pulse", 32'(done1), 32'd0);
        check("p1_idle_busy", 32'(busy1), 32'd0);
        check("p1_sad_hold", 32'(sad1), 32'd2);

        // len=3 with signed extremes: 11 + 0 + 65535
        pulse_start(8'd3);
        check("p3_sad_cleared", 32'(sad1), 32'd0);
        send_pair(16'hFFF9, 16'd4);
        send_pair(16'd100, 16'd100);
        send_pair(16'h8000, 16'h7FFF);
        wait_done();
        check("p3_sad", 32'(sad1), 32'd65546);
        check("p3_ovf", 32'(ovf1), 32'd0);
        @(negedge clk);

        // len=0: immediate done, sad cleared, no handshake
        pulse_start(8'd0);
        check("z_done", 32'(done1), 32'd1);
        check("z_sad", 32'(sad1), 32'd0);
        check("z_in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        check("z_done_pulse", 32'(done1), 32'd0);
        check("z_in_ready2", 32'(in_ready1), 32'd0);
        check("z_busy", 32'(busy1), 32'd0);

        // Saturation in the 17-bit instance; 24-bit instance holds the full sum
        pulse_start(8'd3);
        repeat (3) send_pair(16'h8000, 16'h7FFF);
        wait_done();
        check("sat_sad17", 32'(sad2), 32'd131071);
        check("sat_ovf17", 32'(ovf2), 32'd1);
        check("sat_done17", 32'(done2), 32'd1);
        check("sat_sad24", 32'(sad1), 32'd196605);
        check("sat_ovf24", 32'(ovf1), 32'd0);
        @(negedge clk);
        check("sat_ovf_hold", 32'(ovf2), 32'd1);
        pulse_start(8'd1);
        check("sat_ovf_cleared", 32'(ovf2), 32'd0);
        send_pair(16'd0, 16'd1);
        wait_done();
        check("sat_after_sad", 32'(sad2), 32'd1);
        @(negedge clk);

        // len=2 with a 5-cycle valid stall in LOAD and a stray start
        pulse_start(8'd2);
        a = 16'd1234;
        b = 16'd4321;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_ready_%0d", i), 32'(in_ready1), 32'd1);
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("stall_sad", 32'(sad1), 32'd0);
        send_pair(16'd10, 16'hFFF6);
        start = 1'b1;
        len   = 8'd9;
        @(negedge clk);
        start = 1'b0;
        send_pair(16'd3, 16'd8);
        wait_done();
        check("stall_sad_final", 32'(sad1), 32'd25);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("stall_no_restart", 32'(busy1), 32'd0);

        // Reset during ABS of pair 2 aborts the block asynchronously
        pulse_start(8'd3);
        send_pair(16'd50, 16'd20);
        send_pair(16'd7, 16'd1);
        @(negedge clk);
        check("pre_rst_sad", 32'(sad1), 32'd30);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready1), 32'd0);
        check("arst_busy", 32'(busy1), 32'd0);
        check("arst_done", 32'(done1), 32'd0);
        check("arst_sad", 32'(sad1), 32'd0);
        check("arst_ovf", 32'(ovf1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(8'd1);
        send_pair(16'd1, 16'd9);
        wait_done();
        check("post_rst_sad", 32'(sad1), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
